sfo_search_controller: RTL and testbench

Sequences one sfo_fft_correlator instance across a sweep of SFO hypotheses for a single CFO hypothesis. For each hypothesis it:
- presents the SFO value and pulses the correlator reset;
- streams all FFT-magnitude bins from the bin RAM, addressing it and qualifying each bin with an update strobe;
- waits for the correlation result;
- tracks the best result that meets the threshold.
It sits between the FFT-magnitude bin RAM and the correlator, and reports the winning hypothesis to the gateway control logic.

---
 rtl/sfo_search_controller_if.sv | 49 ++++
 rtl/sfo_search_controller.sv | 173 +++++++++++++++++
 tb/tb_sfo_search_controller.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sfo_search_controller_if.sv
// Bus bundle between the SFO search controller, the FFT-magnitude bin RAM,
// the sfo_fft_correlator and the gateway control logic.
interface sfo_search_controller_if #(
    parameter int FFT_LEN_LOG2   = 9,
    parameter int SFO_INT_WIDTH  = 8,
    parameter int SFO_FRAC_WIDTH = 16,
    parameter int CORR_WIDTH     = 32,
    parameter int NUM_HYP_LOG2   = 6
) ();
    logic                      start;
    logic                      abort;
    logic [SFO_INT_WIDTH-1:0]  sfo_start_int;
    logic [SFO_FRAC_WIDTH-1:0] sfo_start_frac;
    logic [SFO_FRAC_WIDTH-1:0] sfo_step_frac;
    logic [NUM_HYP_LOG2:0]     num_hyp;
    logic [FFT_LEN_LOG2-1:0]   bin_rd_addr;
    logic [SFO_INT_WIDTH-1:0]  corr_sfo_int;
    logic [SFO_FRAC_WIDTH-1:0] corr_sfo_frac;
    logic                      corr_reset;
    logic                      corr_update;
    logic [CORR_WIDTH:0]       correlation_in;
    logic                      correlation_valid;
    logic                      busy;
    logic                      done;
    logic                      best_valid;
    logic [NUM_HYP_LOG2-1:0]   best_index;
    logic [SFO_INT_WIDTH-1:0]  best_sfo_int;
    logic [SFO_FRAC_WIDTH-1:0] best_sfo_frac;
    logic [CORR_WIDTH-1:0]     best_corr;
    logic                      timeout_flag;

    // Gateway / correlator side
    modport master (
        output start, abort, sfo_start_int, sfo_start_frac, sfo_step_frac, num_hyp,
               correlation_in, correlation_valid,
        input  bin_rd_addr, corr_sfo_int, corr_sfo_frac, corr_reset, corr_update,
               busy, done, best_valid, best_index, best_sfo_int, best_sfo_frac,
               best_corr, timeout_flag
    );

    // Controller side
    modport slave (
        input  start, abort, sfo_start_int, sfo_start_frac, sfo_step_frac, num_hyp,
               correlation_in, correlation_valid,
        output bin_rd_addr, corr_sfo_int, corr_sfo_frac, corr_reset, corr_update,
               busy, done, best_valid, best_index, best_sfo_int, best_sfo_frac,
               best_corr, timeout_flag
    );
endinterface

// File: rtl/sfo_search_controller.sv
// Sweeps one sfo_fft_correlator across a run of SFO hypotheses, streaming the
// FFT-magnitude bins for each and keeping the strongest above-threshold result.
module sfo_search_controller #(
    parameter int FFT_LEN_LOG2   = 9,
    parameter int SFO_INT_WIDTH  = 8,
    parameter int SFO_FRAC_WIDTH = 16,
    parameter int CORR_WIDTH     = 32,
    parameter int NUM_HYP_LOG2   = 6,
    parameter int TIMEOUT        = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    sfo_search_controller_if.slave bus
);
    localparam int N     = 1 << FFT_LEN_LOG2;
    localparam int CNT_W = FFT_LEN_LOG2 + 1;
    localparam int HYP_W = NUM_HYP_LOG2 + 1;
    localparam int SFO_W = SFO_INT_WIDTH + SFO_FRAC_WIDTH;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, CRESET, STREAM, WAIT, COMPARE, NEXT} state_t;

    state_t                    state, state_nxt;
    logic [SFO_W-1:0]          hyp_sfo;
    logic [SFO_FRAC_WIDTH-1:0] step_frac_r;
    logic [HYP_W-1:0]          num_hyp_r;
    logic [HYP_W-1:0]          hyp_cnt;
    logic [CNT_W-1:0]          stream_cnt;
    logic [FFT_LEN_LOG2-1:0]   rd_addr;
    logic                      upd_r;
    logic [TMO_W-1:0]          wait_cnt;
    logic [CORR_WIDTH:0]       corr_cap;
    logic                      busy_r;
    logic                      done_r;
    logic                      tmo_r;
    logic                      best_valid_r;
    logic [NUM_HYP_LOG2-1:0]   best_index_r;
    logic [SFO_W-1:0]          best_sfo_r;
    logic [CORR_WIDTH-1:0]     best_corr_r;

    logic                      last_stream;
    logic                      wait_expired;
    logic                      hyp_last;
    logic [CORR_WIDTH-1:0]     cand_mag;
    logic                      cand_wins;

    assign last_stream  = (stream_cnt == CNT_W'(N));
    assign wait_expired = (wait_cnt == TMO_W'(TIMEOUT - 1));
    assign hyp_last     = ((hyp_cnt + HYP_W'(1)) == num_hyp_r);
    assign cand_mag     = corr_cap[CORR_WIDTH-1:0];
    // Strictly greater, so ties leave the earlier hypothesis in place
    assign cand_wins    = corr_cap[CORR_WIDTH] && (!best_valid_r || (cand_mag > best_corr_r));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.start && (bus.num_hyp != '0)) state_nxt = CRESET;
                CRESET:  state_nxt = STREAM;
                STREAM:  if (last_stream) state_nxt = WAIT;
                WAIT: begin
                    if (bus.correlation_valid) state_nxt = COMPARE;
                    else if (wait_expired)     state_nxt = NEXT;
                end
                COMPARE: state_nxt = NEXT;
                NEXT:    state_nxt = hyp_last ? IDLE : CRESET;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hyp_sfo      <= '0;
            step_frac_r  <= '0;
            num_hyp_r    <= '0;
            hyp_cnt      <= '0;
            stream_cnt   <= '0;
            rd_addr      <= '0;
            upd_r        <= 1'b0;
            wait_cnt     <= '0;
            corr_cap     <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            tmo_r        <= 1'b0;
            best_valid_r <= 1'b0;
            best_index_r <= '0;
            best_sfo_r   <= '0;
            best_corr_r  <= '0;
        end else begin
            done_r <= 1'b0;
            // Strobe lags the address by one cycle to line up with RAM read data
            upd_r  <= !bus.abort && (state == STREAM) && !last_stream;
            if (bus.abort) begin
                busy_r <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            best_valid_r <= 1'b0;
                            best_index_r <= '0;
                            best_sfo_r   <= '0;
                            best_corr_r  <= '0;
                            tmo_r        <= 1'b0;
                            hyp_cnt      <= '0;
                            if (bus.num_hyp == '0) begin
                                done_r <= 1'b1;
                            end else begin
                                hyp_sfo     <= {bus.sfo_start_int, bus.sfo_start_frac};
                                step_frac_r <= bus.sfo_step_frac;
                                num_hyp_r   <= bus.num_hyp;
                                busy_r      <= 1'b1;
                            end
                        end
                    end
                    CRESET: begin
                        stream_cnt <= '0;
                        rd_addr    <= '0;
                    end
                    STREAM: begin
                        stream_cnt <= stream_cnt + CNT_W'(1);
                        if (stream_cnt < CNT_W'(N - 1)) rd_addr <= rd_addr + FFT_LEN_LOG2'(1);
                        wait_cnt   <= '0;
                    end
                    WAIT: begin
                        if (bus.correlation_valid) corr_cap <= bus.correlation_in;
                        else if (wait_expired)     tmo_r    <= 1'b1;
                        else                       wait_cnt <= wait_cnt + TMO_W'(1);
                    end
                    COMPARE: begin
                        if (cand_wins) begin
                            best_valid_r <= 1'b1;
                            best_index_r <= hyp_cnt[NUM_HYP_LOG2-1:0];
                            best_sfo_r   <= hyp_sfo;
                            best_corr_r  <= cand_mag;
                        end
                    end
                    NEXT: begin
                        // Integer part wraps naturally at the top of the concatenation
                        hyp_sfo <= hyp_sfo + {{SFO_INT_WIDTH{1'b0}}, step_frac_r};
                        hyp_cnt <= hyp_cnt + HYP_W'(1);
                        if (hyp_last) begin
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.bin_rd_addr   = rd_addr;
    assign bus.corr_sfo_int  = hyp_sfo[SFO_W-1:SFO_FRAC_WIDTH];
    assign bus.corr_sfo_frac = hyp_sfo[SFO_FRAC_WIDTH-1:0];
    assign bus.corr_reset    = (state == CRESET);
    assign bus.corr_update   = upd_r;
    assign bus.busy          = busy_r;
    assign bus.done          = done_r;
    assign bus.best_valid    = best_valid_r;
    assign bus.best_index    = best_index_r;
    assign bus.best_sfo_int  = best_sfo_r[SFO_W-1:SFO_FRAC_WIDTH];
    assign bus.best_sfo_frac = best_sfo_r[SFO_FRAC_WIDTH-1:0];
    assign bus.best_corr     = best_corr_r;
    assign bus.timeout_flag  = tmo_r;
endmodule

// File: tb/tb_sfo_search_controller.sv
// Bench for sfo_search_controller: a correlator model scoreboards the SFO
// hypothesis sequence and address stream; each scenario checks the sweep result.
module tb_sfo_search_controller;
    localparam int FL2 = 9;
    localparam int SI  = 8;
    localparam int SF  = 16;
    localparam int CW  = 32;
    localparam int NH2 = 6;
    localparam int TMO = 64;
    localparam int N   = 1 << FL2;

    logic clk = 1'b0;
    logic reset;

    sfo_search_controller_if #(.FFT_LEN_LOG2(FL2), .SFO_INT_WIDTH(SI), .SFO_FRAC_WIDTH(SF),
                               .CORR_WIDTH(CW), .NUM_HYP_LOG2(NH2)) bus ();

    sfo_search_controller #(.FFT_LEN_LOG2(FL2), .SFO_INT_WIDTH(SI), .SFO_FRAC_WIDTH(SF),
                            .CORR_WIDTH(CW), .NUM_HYP_LOG2(NH2), .TIMEOUT(TMO))
        dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    logic [23:0] exp_sfo_q[$];
    logic [32:0] res[8];
    bit          never_valid[8];
    int hyp_seen = 0, cur_hyp = 0, upd_cnt = 0, upd_total = 0, addr_err = 0;
    int done_cnt = 0, reset_cnt = 0, delay_left = 0, cyc = 0, last_upd_cyc = 0;
    bit armed = 0;
    int gap[8];
    logic [8:0] prev_addr = '0;

    function automatic logic [64:0] best_tuple();
        return {bus.best_valid, bus.best_index, bus.best_sfo_int, bus.best_sfo_frac,
                bus.best_corr, bus.timeout_flag, bus.busy};
    endfunction

    // Correlator + RAM-side model: pops the expected hypothesis at every corr_reset,
    // checks the address under each update and answers 10 cycles after the last bin.
    task automatic correlator_model();
        logic [23:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset === 1'b1) begin
                bus.correlation_valid = 1'b0;
                bus.correlation_in    = '0;
                armed = 0;
            end else begin
                if (bus.corr_reset === 1'b1) begin
                    if (hyp_seen > 0 && upd_cnt != N) addr_err++;
                    if (hyp_seen < 8) gap[hyp_seen] = cyc - last_upd_cyc;
                    cur_hyp = hyp_seen;
                    hyp_seen++;
                    reset_cnt++;
                    upd_cnt = 0;
                    armed = 0;
                    bus.correlation_valid = 1'b0;
                    n_cmp++;
                    if (exp_sfo_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL sfo_scoreboard got corr_reset with sfo %h.%h, required none",
                                 bus.corr_sfo_int, bus.corr_sfo_frac);
                    end else begin
                        e = exp_sfo_q.pop_front();
                        if ({bus.corr_sfo_int, bus.corr_sfo_frac} !== e) begin
                            n_fail++;
                            $display("FAIL sfo_scoreboard got %h.%h required %h.%h",
                                     bus.corr_sfo_int, bus.corr_sfo_frac, e[23:16], e[15:0]);
                        end
                    end
                end
                if (bus.corr_update === 1'b1) begin
                    if (prev_addr !== upd_cnt[8:0]) addr_err++;
                    upd_cnt++;
                    upd_total++;
                    last_upd_cyc = cyc;
                    if (upd_cnt == N) begin
                        armed = 1;
                        delay_left = 10;
                    end
                end else if (armed) begin
                    delay_left--;
                    if (delay_left == 0) begin
                        armed = 0;
                        if (!never_valid[cur_hyp]) begin
                            bus.correlation_in    = res[cur_hyp];
                            bus.correlation_valid = 1'b1;
                        end
                    end
                end
                if (bus.done === 1'b1) done_cnt++;
            end
            prev_addr = bus.bin_rd_addr;
        end
    endtask

    task automatic start_sweep(input int num, input logic [7:0] si, input logic [15:0] sf,
                               input logic [15:0] st);
        logic [23:0] v;
        @(negedge clk);
        hyp_seen = 0; upd_cnt = 0; armed = 0; reset_cnt = 0;
        upd_total = 0; addr_err = 0; done_cnt = 0;
        exp_sfo_q.delete();
        v = {si, sf};
        for (int i = 0; i < num; i++) begin
            exp_sfo_q.push_back(v);
            v = v + {8'h00, st};
        end
        bus.num_hyp        = 7'(num);
        bus.sfo_start_int  = si;
        bus.sfo_start_frac = sf;
        bus.sfo_step_frac  = st;
        bus.start          = 1'b1;
        @(negedge clk);
        bus.start          = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (bus.done !== 1'b1 && k < 20000) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (bus.done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_done got no done within 20000 cycles required a done pulse", tag);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus.busy, bus.done, best_tuple(), bus.corr_reset, bus.corr_update, bus.bin_rd_addr,
             bus.corr_sfo_int, bus.corr_sfo_frac} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got best=%h addr=%h sfo=%h.%h required all zero",
                     best_tuple(), bus.bin_rd_addr, bus.corr_sfo_int, bus.corr_sfo_frac);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.busy, bus.corr_reset, bus.corr_update} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_idle got busy/creset/upd=%b required 000",
                     {bus.busy, bus.corr_reset, bus.corr_update});
        end
    endtask

    task automatic test_single();
        res[0] = {1'b1, 32'd100};
        start_sweep(1, 8'h05, 16'h0000, 16'h0000);
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL single_busy got %b required 1", bus.busy);
        end
        wait_done("single");
        n_cmp++;
        if (best_tuple() !== {1'b1, 6'd0, 8'h05, 16'h0000, 32'd100, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL single_result got %h required %h", best_tuple(),
                               {1'b1, 6'd0, 8'h05, 16'h0000, 32'd100, 1'b0, 1'b0});
        end
        @(negedge clk);
        n_cmp++;
        if (bus.done !== 1'b0) begin
            n_fail++; $display("FAIL single_done_width got done=%b one cycle later required 0", bus.done);
        end
        n_cmp++;
        if (upd_total != N || addr_err != 0 || reset_cnt != 1) begin
            n_fail++; $display("FAIL single_stream got %0d updates %0d addr errors %0d resets required %0d/0/1",
                               upd_total, addr_err, reset_cnt, N);
        end
    endtask

    task automatic test_zero_hyp();
        start_sweep(0, 8'h11, 16'h2222, 16'h0001);
        n_cmp++;
        if (bus.done !== 1'b1) begin
            n_fail++; $display("FAIL zero_done got %b in the cycle after start required 1", bus.done);
        end
        n_cmp++;
        if (best_tuple() !== '0) begin
            n_fail++; $display("FAIL zero_result got %h required 0", best_tuple());
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (reset_cnt != 0 || done_cnt != 1) begin
            n_fail++; $display("FAIL zero_idle got %0d resets %0d dones required 0/1", reset_cnt, done_cnt);
        end
    endtask

    task automatic test_sfo_sequence();
        res[0] = {1'b1, 32'd10}; res[1] = {1'b1, 32'd40};
        res[2] = {1'b1, 32'd30}; res[3] = {1'b1, 32'd20};
        start_sweep(4, 8'h04, 16'hC000, 16'h4000);
        wait_done("seq");
        n_cmp++;
        if (best_tuple() !== {1'b1, 6'd1, 8'h05, 16'h0000, 32'd40, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL seq_result got %h required %h", best_tuple(),
                               {1'b1, 6'd1, 8'h05, 16'h0000, 32'd40, 1'b0, 1'b0});
        end
        n_cmp++;
        if (reset_cnt != 4 || upd_total != 4 * N || addr_err != 0 || exp_sfo_q.size() != 0) begin
            n_fail++; $display("FAIL seq_stream got %0d resets %0d updates %0d addr errors %0d left required 4/%0d/0/0",
                               reset_cnt, upd_total, addr_err, exp_sfo_q.size(), 4 * N);
        end
        // Integer part wrap: FF.C000 + 0.8000 -> 00.4000
        res[0] = {1'b1, 32'd3}; res[1] = {1'b1, 32'd9};
        start_sweep(2, 8'hFF, 16'hC000, 16'h8000);
        wait_done("wrap");
        n_cmp++;
        if (best_tuple() !== {1'b1, 6'd1, 8'h00, 16'h4000, 32'd9, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL wrap_result got %h required %h", best_tuple(),
                               {1'b1, 6'd1, 8'h00, 16'h4000, 32'd9, 1'b0, 1'b0});
        end
    endtask

    task automatic test_tie();
        res[0] = {1'b1, 32'd50}; res[1] = {1'b1, 32'd80}; res[2] = {1'b1, 32'd80};
        start_sweep(3, 8'h10, 16'h0000, 16'h0100);
        wait_done("tie");
        n_cmp++;
        if (best_tuple() !== {1'b1, 6'd1, 8'h10, 16'h0100, 32'd80, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL tie_result got %h required %h", best_tuple(),
                               {1'b1, 6'd1, 8'h10, 16'h0100, 32'd80, 1'b0, 1'b0});
        end
    endtask

    task automatic test_flag();
        res[0] = {1'b0, 32'd900}; res[1] = {1'b1, 32'd10};
        start_sweep(2, 8'h01, 16'h0000, 16'h1000);
        wait_done("flag");
        n_cmp++;
        if (best_tuple() !== {1'b1, 6'd1, 8'h01, 16'h1000, 32'd10, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL flag_result got %h required %h", best_tuple(),
                               {1'b1, 6'd1, 8'h01, 16'h1000, 32'd10, 1'b0, 1'b0});
        end
        res[0] = {1'b0, 32'd900}; res[1] = {1'b0, 32'd5};
        start_sweep(2, 8'h01, 16'h0000, 16'h1000);
        wait_done("noflag");
        n_cmp++;
        if (best_tuple() !== '0) begin
            n_fail++; $display("FAIL noflag_result got %h required 0", best_tuple());
        end
    endtask

    task automatic test_timeout();
        never_valid[0] = 1'b1;
        res[1] = {1'b1, 32'd7};
        start_sweep(2, 8'h02, 16'h0000, 16'h0800);
        wait_done("timeout");
        never_valid[0] = 1'b0;
        n_cmp++;
        if (best_tuple() !== {1'b1, 6'd1, 8'h02, 16'h0800, 32'd7, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL timeout_result got %h required %h", best_tuple(),
                               {1'b1, 6'd1, 8'h02, 16'h0800, 32'd7, 1'b1, 1'b0});
        end
        // Last bin -> 64 WAIT cycles -> NEXT -> CRESET of the following hypothesis
        n_cmp++;
        if (gap[1] != TMO + 2) begin
            n_fail++; $display("FAIL timeout_gap got %0d cycles required %0d", gap[1], TMO + 2);
        end
    endtask

    task automatic test_abort();
        int k;
        int base_upd;
        res[0] = {1'b1, 32'd55}; res[1] = {1'b1, 32'd99};
        start_sweep(2, 8'h03, 16'h0000, 16'h0100);
        k = 0;
        while (!(reset_cnt == 1 && upd_cnt >= 50) && k < 5000) begin @(negedge clk); k++; end
        bus.num_hyp = 7'd1;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        k = 0;
        while (!(reset_cnt == 2 && upd_cnt >= 100) && k < 5000) begin @(negedge clk); k++; end
        n_cmp++;
        if (reset_cnt != 2 || upd_cnt < 100) begin
            n_fail++; $display("FAIL abort_reach got %0d resets %0d updates required 2 resets, >=100 updates",
                               reset_cnt, upd_cnt);
        end
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        n_cmp++;
        if ({bus.busy, bus.corr_update} !== 2'b00) begin
            n_fail++; $display("FAIL abort_stop got busy/upd=%b required 00", {bus.busy, bus.corr_update});
        end
        n_cmp++;
        if (best_tuple() !== {1'b1, 6'd0, 8'h03, 16'h0000, 32'd55, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL abort_best got %h required %h", best_tuple(),
                               {1'b1, 6'd0, 8'h03, 16'h0000, 32'd55, 1'b0, 1'b0});
        end
        base_upd = upd_total;
        bus.num_hyp = 7'd1; bus.start = 1'b1; bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0 || upd_total != base_upd || done_cnt != 0 || reset_cnt != 2) begin
            n_fail++; $display("FAIL abort_quiet got busy=%b %0d new updates %0d dones %0d resets required 0/0/0/2",
                               bus.busy, upd_total - base_upd, done_cnt, reset_cnt);
        end
        // Asynchronous reset while waiting for a correlation that never arrives
        never_valid[0] = 1'b1;
        start_sweep(1, 8'h07, 16'h1234, 16'h0000);
        k = 0;
        while (upd_cnt != N && k < 5000) begin @(negedge clk); k++; end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.bin_rd_addr !== 9'd511) begin
            n_fail++; $display("FAIL wait_state got busy=%b addr=%0d required 1/511", bus.busy, bus.bin_rd_addr);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, best_tuple(), bus.corr_reset, bus.corr_update, bus.bin_rd_addr,
             bus.corr_sfo_int, bus.corr_sfo_frac} !== '0) begin
            n_fail++; $display("FAIL async_reset got busy=%b addr=%h sfo=%h.%h best=%h required all zero",
                               bus.busy, bus.bin_rd_addr, bus.corr_sfo_int, bus.corr_sfo_frac, best_tuple());
        end
        @(negedge clk);
        reset = 1'b0;
        never_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (done_cnt != 0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL async_reset_done got %0d dones busy=%b required 0/0", done_cnt, bus.busy);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.sfo_start_int = '0; bus.sfo_start_frac = '0; bus.sfo_step_frac = '0;
        bus.num_hyp = '0;
        bus.correlation_in = '0; bus.correlation_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            res[i] = '0;
            never_valid[i] = 1'b0;
            gap[i] = 0;
        end
        fork
            correlator_model();
        join_none
        test_reset();
        test_single();
        test_zero_hyp();
        test_sfo_sequence();
        test_tie();
        test_flag();
        test_timeout();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
